// File: rtl/nibble_add_seq_if.sv
// nibble_add_seq_if: start/busy/done handshake, operands and result of the sequential nibble adder.
// Carries the optional sub line when NIBBLE_ADD_SEQ_SUB_EN is defined.
interface nibble_add_seq_if #(parameter int NIBBLES = 4);
    logic                   start;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   ci;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    logic                   sub;
`endif
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   s;
    logic                   co;
    modport master(output start, a, b, ci, input busy, done, s, co
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        , output sub
`endif
    );
    modport slave(input start, a, b, ci, output busy, done, s, co
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        , input sub
`endif
    );
endinterface

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: wide add built from one 4-bit slice, one nibble per clock, LSB nibble first.
// Defining NIBBLE_ADD_SEQ_SUB_EN adds a sub input that turns the operation into a - b.
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    nibble_add_seq_if.slave  bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q, b_q, part_q, part_d, s_q;
    logic            busy_q, done_q, co_q;
    logic [3:0]      a_n, b_n;
    logic [4:0]      nsum;
    logic [W-1:0]    b_in;
    logic            c_in;
    logic            last;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry.
    assign b_in = bus.sub ? ~bus.b : bus.b;
    assign c_in = bus.sub ? 1'b1 : bus.ci;
`else
    assign b_in = bus.b;
    assign c_in = bus.ci;
`endif
    assign a_n    = 4'(a_q >> {idx_q, 2'b00});
    assign b_n    = 4'(b_q >> {idx_q, 2'b00});
    assign nsum   = {1'b0, a_n} + {1'b0, b_n} + {4'b0, carry_q};
    assign part_d = part_q | (W'(nsum[3:0]) << {idx_q, 2'b00});
    assign last   = idx_q == IW'(NIBBLES - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (bus.start) begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                    a_q     <= bus.a;
                    b_q     <= b_in;
                    carry_q <= c_in;
                    idx_q   <= '0;
                    part_q  <= '0;
                end
            end else begin
                part_q  <= part_d;
                carry_q <= nsum[4];
                idx_q   <= idx_q + IW'(1);
                if (last) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    s_q     <= part_d;
                    co_q    <= nsum[4];
                    done_q  <= 1'b1;
                end
            end
        end
    end
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.s    = s_q;
    assign bus.co   = co_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: directed vectors on a 4-nibble and a 1-nibble instance, checked against
// a countdown/arithmetic model every cycle plus hand-computed literal results.
module tb_nibble_add_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    nibble_add_seq_if #(.NIBBLES(4)) b4();
    nibble_add_seq_if #(.NIBBLES(1)) b1();
    nibble_add_seq #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    nibble_add_seq #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    int vec = 0;
    int errs = 0;
    logic armed = 1'b0;
    logic sub4, sub1;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    assign sub4 = b4.sub;
    assign sub1 = b1.sub;
`else
    assign sub4 = 1'b0;
    assign sub1 = 1'b0;
`endif
    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [32:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic sub);
        logic [31:0] mask, bb;
        mask = (32'h1 << w) - 32'h1;
        bb = sub ? (~b & mask) : b;
        return {1'b0, a & mask} + {1'b0, bb} + 33'(sub ? 1'b1 : ci);
    endfunction
    // Model: an accepted op stays busy for N cycles, then publishes a+b+ci with a done pulse.
    int m4_cnt = 0, m1_cnt = 0;
    logic [32:0] m4_pend = '0, m4_res = '0, m1_pend = '0, m1_res = '0;
    logic m4_done = 1'b0, m1_done = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            m4_cnt = 0; m4_res = '0; m4_done = 1'b0;
            m1_cnt = 0; m1_res = '0; m1_done = 1'b0;
            armed = 1'b1;
        end else begin
            m4_done = 1'b0;
            if (m4_cnt > 0) begin
                m4_cnt--;
                if (m4_cnt == 0) begin m4_done = 1'b1; m4_res = m4_pend; end
            end else if (b4.start) begin
                m4_cnt = 4;
                m4_pend = ref_add(16, 32'(b4.a), 32'(b4.b), b4.ci, sub4);
            end
            m1_done = 1'b0;
            if (m1_cnt > 0) begin
                m1_cnt--;
                if (m1_cnt == 0) begin m1_done = 1'b1; m1_res = m1_pend; end
            end else if (b1.start) begin
                m1_cnt = 1;
                m1_pend = ref_add(4, 32'(b1.a), 32'(b1.b), b1.ci, sub1);
            end
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("busy4", 33'(b4.busy), 33'(m4_cnt > 0));
            chk("done4", 33'(b4.done), 33'(m4_done));
            chk("s4", 33'(b4.s), 33'(m4_res[15:0]));
            chk("co4", 33'(b4.co), 33'(m4_res[16]));
            chk("busy1", 33'(b1.busy), 33'(m1_cnt > 0));
            chk("done1", 33'(b1.done), 33'(m1_done));
            chk("s1", 33'(b1.s), 33'(m1_res[3:0]));
            chk("co1", 33'(b1.co), 33'(m1_res[4]));
        end
    end
    task automatic start4(input logic [15:0] a, input logic [15:0] b, input logic ci);
        b4.a = a; b4.b = b; b4.ci = ci; b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
    endtask
    task automatic wait4(output int n, output int nb);
        n = 1; nb = 0;
        while (!b4.done && n < 30) begin
            nb += int'(b4.busy);
            @(negedge clk);
            n++;
        end
        if (!b4.done) chk("timeout4", 33'(b4.done), 33'd1);
    endtask
    int n, nb, dn;
    logic [15:0] cap;
    initial begin
        b4.start = 0; b4.a = 0; b4.b = 0; b4.ci = 0;
        b1.start = 0; b1.a = 0; b1.b = 0; b1.ci = 0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        b4.sub = 0; b1.sub = 0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", 33'(b4.busy), 33'd0);
        chk("rst_s", 33'(b4.s), 33'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start4(16'h1234, 16'h0FCD, 1'b0);
        wait4(n, nb);
        chk("lat4", 33'(n), 33'd5);
        chk("busycyc4", 33'(nb), 33'd4);
        chk("sum_1234", 33'(b4.s), 33'h2201);
        chk("co_1234", 33'(b4.co), 33'd0);
        @(negedge clk);
        start4(16'hFFFF, 16'h0001, 1'b0);
        wait4(n, nb);
        chk("sum_ffff", 33'(b4.s), 33'h0000);
        chk("co_ffff", 33'(b4.co), 33'd1);
        start4(16'h0000, 16'h0000, 1'b1);
        n = 1;
        while (!b4.done && n < 30) begin
            chk("hold_s", 33'(b4.s), 33'h0000);
            @(negedge clk);
            n++;
        end
        chk("b2b_lat", 33'(n), 33'd5);
        chk("sum_ci", 33'(b4.s), 33'h0001);
        chk("co_ci", 33'(b4.co), 33'd0);
        @(negedge clk);
        start4(16'h0102, 16'h0304, 1'b1);
        @(negedge clk);
        b4.a = 16'hFFFF; b4.b = 16'hFFFF; b4.start = 1'b1;
        @(negedge clk);
        b4.start = 1'b0;
        dn = 0; cap = '0;
        repeat (12) begin
            if (b4.done) begin dn++; cap = b4.s; end
            @(negedge clk);
        end
        chk("one_done", 33'(dn), 33'd1);
        chk("sum_ignored", 33'(cap), 33'h0407);
        start4(16'h5555, 16'h1111, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy2", 33'(b4.busy), 33'd0);
        chk("rst_s2", 33'(b4.s), 33'd0);
        chk("rst_done2", 33'(b4.done), 33'd0);
        rst_n = 1'b1;
        dn = 0;
        repeat (8) begin
            dn += int'(b4.done);
            @(negedge clk);
        end
        chk("no_done_rst", 33'(dn), 33'd0);
        start4(16'h0008, 16'h0009, 1'b0);
        wait4(n, nb);
        chk("sum_after_rst", 33'(b4.s), 33'h0011);
        b1.a = 4'h9; b1.b = 4'h8; b1.ci = 1'b1; b1.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        n = 1; nb = 0;
        while (!b1.done && n < 30) begin
            nb += int'(b1.busy);
            @(negedge clk);
            n++;
        end
        chk("lat1", 33'(n), 33'd2);
        chk("busycyc1", 33'(nb), 33'd1);
        chk("sum1", 33'(b1.s), 33'h2);
        chk("co1_lit", 33'(b1.co), 33'd1);
`ifdef NIBBLE_ADD_SEQ_SUB_EN
        @(negedge clk);
        b4.sub = 1'b1;
        start4(16'h1000, 16'h0001, 1'b0);
        wait4(n, nb);
        chk("sub_s1", 33'(b4.s), 33'h0FFF);
        chk("sub_co1", 33'(b4.co), 33'd1);
        @(negedge clk);
        start4(16'h0001, 16'h0002, 1'b1);
        wait4(n, nb);
        chk("sub_s2", 33'(b4.s), 33'hFFFF);
        chk("sub_co2", 33'(b4.co), 33'd0);
        b4.sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
